// File: rtl/aer_pkg.sv
// Shared types and constants for the AER transmit path.
package aer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK_HI,
    WAIT_ACK_LO
  } aer_state_e;

  localparam int AER_ADDR_W = 8;
  localparam int EVT_CNT_W  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or above ptr, wrapping upward.
module rr_arbiter #(
  parameter  int NUM_SRC = 4,
  localparam int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset back to the pointer so the nearest request is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_SRC);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/aer_tx_arbiter.sv
// Shares one AER output bus between NUM_SRC spike sources: round-robin grant,
// full 4-phase REQ/ACK sequencing, stuck-ACK timeout and a saturating event count.
module aer_tx_arbiter
  import aer_pkg::*;
#(
  parameter  int NUM_SRC     = 4,
  parameter  int ADDR_W      = AER_ADDR_W,
  parameter  int TIMEOUT_CYC = 255,
  parameter  bit SYNC_ACK    = 1'b0,
  localparam int IDX_W       = $clog2(NUM_SRC)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_SRC-1:0]        SRC_VALID,
  input  logic [NUM_SRC*ADDR_W-1:0] SRC_ADDR,
  output logic [NUM_SRC-1:0]        SRC_READY,
  output logic                      AEROUT_REQ,
  output logic [ADDR_W-1:0]         AEROUT_ADDR,
  input  logic                      AEROUT_ACK,
  output logic [IDX_W-1:0]          GRANT_ID,
  output logic                      ERR_TIMEOUT,
  output logic [EVT_CNT_W-1:0]      EVT_CNT
);

  localparam int              TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit              TO_EN   = (TIMEOUT_CYC != 0);

  aer_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [TO_W-1:0]  to_cnt;
  logic             ack_s;
  logic [NUM_SRC-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               transfer;

  // The receiver may sit in another clock domain, so ACK can optionally be double-flopped.
  if (SYNC_ACK) begin : g_ack_sync
    logic [1:0] ack_ff;
    always_ff @(posedge CLK) begin
      if (RST) ack_ff <= '0;
      else     ack_ff <= {ack_ff[0], AEROUT_ACK};
    end
    assign ack_s = ack_ff[1];
  end else begin : g_ack_direct
    assign ack_s = AEROUT_ACK;
  end

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req       (SRC_VALID),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // A late ACK left over from an aborted transfer blocks new grants until it drops.
  assign SRC_READY = (state == IDLE && !ack_s) ? arb_grant : '0;
  assign transfer  = |(SRC_VALID & SRC_READY);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      ptr         <= '0;
      to_cnt      <= '0;
      AEROUT_REQ  <= 1'b0;
      AEROUT_ADDR <= '0;
      GRANT_ID    <= '0;
      ERR_TIMEOUT <= 1'b0;
      EVT_CNT     <= '0;
    end else begin
      ERR_TIMEOUT <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            AEROUT_ADDR <= SRC_ADDR[arb_idx*ADDR_W +: ADDR_W];
            GRANT_ID    <= arb_idx;
            AEROUT_REQ  <= 1'b1;
            ptr         <= (arb_idx == IDX_W'(NUM_SRC - 1)) ? '0 : arb_idx + 1'b1;
            to_cnt      <= '0;
            state       <= WAIT_ACK_HI;
          end
        end
        WAIT_ACK_HI: begin
          to_cnt <= to_cnt + 1'b1;
          // ACK takes precedence over a timeout landing in the same cycle.
          if (ack_s) begin
            AEROUT_REQ <= 1'b0;
            if (EVT_CNT != '1) EVT_CNT <= EVT_CNT + 1'b1;
            state <= WAIT_ACK_LO;
          end else if (TO_EN && to_cnt == TO_LAST) begin
            AEROUT_REQ  <= 1'b0;
            ERR_TIMEOUT <= 1'b1;
            state       <= WAIT_ACK_LO;
          end
        end
        WAIT_ACK_LO: begin
          if (!ack_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aer_tx_arbiter.sv
// Self-checking bench for aer_tx_arbiter: directed scenarios plus randomized traffic against a cycle-count model.
module tb_aer_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          fails  = 0;

  logic [3:0]  v0 = '0, v1 = '0;
  logic [31:0] a0 = '0, a1 = '0;
  logic [3:0]  r0, r1;
  logic        req0, req1, err0, err1;
  logic [7:0]  addr0, addr1;
  logic [1:0]  gid0, gid1;
  logic [15:0] cnt0, cnt1;
  logic        ack0, ack1;
  logic        auto0 = 1'b1, man_ack0 = 1'b0;
  logic        ack0_reg = 1'b0, ack1_reg = 1'b0;

  always #5 clk = ~clk;

  // Same-clock receivers that acknowledge one cycle after REQ
  always @(posedge clk) begin
    ack0_reg <= req0;
    ack1_reg <= req1;
  end
  assign ack0 = auto0 ? ack0_reg : man_ack0;
  assign ack1 = ack1_reg;

  aer_tx_arbiter #(.NUM_SRC(4), .ADDR_W(8), .TIMEOUT_CYC(8), .SYNC_ACK(1'b0)) dut0 (
    .CLK(clk), .RST(rst), .SRC_VALID(v0), .SRC_ADDR(a0), .SRC_READY(r0),
    .AEROUT_REQ(req0), .AEROUT_ADDR(addr0), .AEROUT_ACK(ack0),
    .GRANT_ID(gid0), .ERR_TIMEOUT(err0), .EVT_CNT(cnt0));

  aer_tx_arbiter #(.NUM_SRC(4), .ADDR_W(8), .TIMEOUT_CYC(255), .SYNC_ACK(1'b1)) dut1 (
    .CLK(clk), .RST(rst), .SRC_VALID(v1), .SRC_ADDR(a1), .SRC_READY(r1),
    .AEROUT_REQ(req1), .AEROUT_ADDR(addr1), .AEROUT_ACK(ack1),
    .GRANT_ID(gid1), .ERR_TIMEOUT(err1), .EVT_CNT(cnt1));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v0 = '0; v1 = '0; auto0 = 1'b1; man_ack0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v0 = '0; v1 = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_req0 got %b exp 0", req0); end
    checks++; if (addr0 !== 8'h00) begin fails++; $display("[TB] FAIL reset_addr0 got %h exp 00", addr0); end
    checks++; if (gid0 !== 2'd0) begin fails++; $display("[TB] FAIL reset_gid0 got %0d exp 0", gid0); end
    checks++; if (err0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_err0 got %b exp 0", err0); end
    checks++; if (cnt0 !== 16'h0) begin fails++; $display("[TB] FAIL reset_cnt0 got %h exp 0000", cnt0); end
    checks++; if (r0 !== 4'b0) begin fails++; $display("[TB] FAIL reset_ready0 got %b exp 0000", r0); end
    checks++; if (req1 !== 1'b0) begin fails++; $display("[TB] FAIL reset_req1 got %b exp 0", req1); end
    checks++; if (cnt1 !== 16'h0) begin fails++; $display("[TB] FAIL reset_cnt1 got %h exp 0000", cnt1); end
    rst = 1'b0;
  endtask

  task automatic test_single_source();
    do_reset();
    @(negedge clk);
    v0 = 4'b0001; a0 = {24'h0, 8'hA5};
    #1;
    checks++; if (r0 !== 4'b0001) begin fails++; $display("[TB] FAIL single_grant got %b exp 0001", r0); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      v0 = (k >= 4) ? 4'b0001 : 4'b0000;
      #1;
      checks++; if (req0 !== ((k == 1) || (k == 2))) begin fails++; $display("[TB] FAIL single_req k=%0d got %b", k, req0); end
      if (k <= 2) begin
        checks++; if (addr0 !== 8'hA5) begin fails++; $display("[TB] FAIL single_addr k=%0d got %h exp a5", k, addr0); end
      end
      checks++; if (cnt0 !== ((k >= 3) ? 16'd1 : 16'd0)) begin fails++; $display("[TB] FAIL single_cnt k=%0d got %0d", k, cnt0); end
      checks++; if (r0 !== ((k == 5) ? 4'b0001 : 4'b0000)) begin fails++; $display("[TB] FAIL single_ready k=%0d got %b", k, r0); end
    end
  endtask

  task automatic test_fairness();
    logic [7:0] obs [5];
    int         nobs = 0;
    int         rdy_cnt [4];
    logic       prev_req = 1'b0;
    logic [7:0] exp_a;
    for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
    for (int j = 0; j < 5; j++) obs[j] = '0;
    do_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      v0 = 4'hF; a0 = {8'h13, 8'h12, 8'h11, 8'h10};
      #1;
      if (cyc < 20) for (int i = 0; i < 4; i++) if (r0[i]) rdy_cnt[i]++;
      if (req0 && !prev_req) begin
        if (nobs < 5) obs[nobs] = addr0;
        nobs++;
      end
      prev_req = req0;
    end
    checks++; if (nobs < 5) begin fails++; $display("[TB] FAIL fair_events got %0d exp >=5", nobs); end
    for (int j = 0; j < 5; j++) begin
      exp_a = 8'h10 + 8'(j % 4);
      checks++; if (obs[j] !== exp_a) begin fails++; $display("[TB] FAIL fair_order[%0d] got %h exp %h", j, obs[j], exp_a); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rdy_cnt[i] != 1) begin fails++; $display("[TB] FAIL fair_ready_count[%0d] got %0d exp 1", i, rdy_cnt[i]); end
    end
  endtask

  // Model: a grant frees the bus 5 cycles later, REQ is high for the 2 cycles after grant,
  // and the count advances 3 cycles after grant; winners are picked round-robin from pending sources.
  task automatic test_random();
    logic [3:0] pend = '0;
    logic [7:0] paddr [4];
    int         age = 100;
    int         ptr = 0;
    int         w;
    logic [7:0] exp_addr = '0;
    logic [1:0] exp_gid = '0;
    int         exp_cnt = 0;
    logic [3:0] exp_ready;
    do_reset();
    for (int i = 0; i < 4; i++) paddr[i] = 8'($urandom);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (age < 100) age++;
      if (age == 3) exp_cnt++;
      v0 = pend; a0 = {paddr[3], paddr[2], paddr[1], paddr[0]};
      #1;
      exp_ready = '0; w = -1;
      if (age >= 5)
        for (int k = 0; k < 4; k++)
          if (w < 0 && pend[(ptr + k) % 4]) w = (ptr + k) % 4;
      if (w >= 0) exp_ready[w] = 1'b1;
      checks++; if (r0 !== exp_ready) begin fails++; $display("[TB] FAIL rand_ready cyc=%0d got %b exp %b", cyc, r0, exp_ready); end
      checks++; if (req0 !== ((age == 1) || (age == 2))) begin fails++; $display("[TB] FAIL rand_req cyc=%0d got %b age=%0d", cyc, req0, age); end
      checks++; if (addr0 !== exp_addr) begin fails++; $display("[TB] FAIL rand_addr cyc=%0d got %h exp %h", cyc, addr0, exp_addr); end
      checks++; if (gid0 !== exp_gid) begin fails++; $display("[TB] FAIL rand_gid cyc=%0d got %0d exp %0d", cyc, gid0, exp_gid); end
      checks++; if (cnt0 !== 16'(exp_cnt)) begin fails++; $display("[TB] FAIL rand_cnt cyc=%0d got %0d exp %0d", cyc, cnt0, exp_cnt); end
      checks++; if (err0 !== 1'b0) begin fails++; $display("[TB] FAIL rand_err cyc=%0d got %b exp 0", cyc, err0); end
      if (w >= 0) begin
        age = 0; exp_addr = paddr[w]; exp_gid = 2'(w);
        ptr = (w + 1) % 4; pend[w] = 1'b0;
      end
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1; paddr[i] = 8'($urandom);
        end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    auto0 = 1'b0; man_ack0 = 1'b0;
    @(negedge clk);
    v0 = 4'b0100; a0 = {8'h3C, 8'h5C, 8'h00, 8'h00};
    #1;
    checks++; if (r0 !== 4'b0100) begin fails++; $display("[TB] FAIL to_grant got %b exp 0100", r0); end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      v0 = (k == 10) ? 4'b1000 : 4'b0000;
      #1;
      if (k <= 10) begin
        checks++; if (req0 !== (k <= 8)) begin fails++; $display("[TB] FAIL to_req k=%0d got %b", k, req0); end
      end
      checks++; if (err0 !== (k == 9)) begin fails++; $display("[TB] FAIL to_err k=%0d got %b", k, err0); end
      checks++; if (cnt0 !== 16'd0) begin fails++; $display("[TB] FAIL to_cnt k=%0d got %0d exp 0", k, cnt0); end
      if (k == 1) begin
        checks++; if (addr0 !== 8'h5C) begin fails++; $display("[TB] FAIL to_addr got %h exp 5c", addr0); end
        checks++; if (gid0 !== 2'd2) begin fails++; $display("[TB] FAIL to_gid got %0d exp 2", gid0); end
      end
      if (k == 10) begin
        checks++; if (r0 !== 4'b1000) begin fails++; $display("[TB] FAIL to_next_grant got %b exp 1000", r0); end
      end
      if (k == 11) begin
        checks++; if (req0 !== 1'b1) begin fails++; $display("[TB] FAIL to_next_req got %b exp 1", req0); end
        checks++; if (addr0 !== 8'h3C) begin fails++; $display("[TB] FAIL to_next_addr got %h exp 3c", addr0); end
        checks++; if (gid0 !== 2'd3) begin fails++; $display("[TB] FAIL to_next_gid got %0d exp 3", gid0); end
      end
    end
  endtask

  task automatic test_late_ack();
    do_reset();
    auto0 = 1'b0; man_ack0 = 1'b0;
    @(negedge clk);
    v0 = 4'b0010; a0 = {8'h00, 8'h00, 8'h77, 8'h0A};
    #1;
    checks++; if (r0 !== 4'b0010) begin fails++; $display("[TB] FAIL late_grant got %b exp 0010", r0); end
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      v0 = (k >= 12 && k <= 16) ? 4'b0001 : 4'b0000;
      man_ack0 = (k >= 12 && k <= 15);
      #1;
      checks++; if (err0 !== (k == 9)) begin fails++; $display("[TB] FAIL late_err k=%0d got %b", k, err0); end
      checks++; if (cnt0 !== 16'd0) begin fails++; $display("[TB] FAIL late_cnt k=%0d got %0d exp 0", k, cnt0); end
      if (k >= 9 && k <= 16) begin
        checks++; if (req0 !== 1'b0) begin fails++; $display("[TB] FAIL late_req k=%0d got %b exp 0", k, req0); end
      end
      if (k >= 10 && k <= 16) begin
        checks++; if (r0 !== ((k == 16) ? 4'b0001 : 4'b0000)) begin fails++; $display("[TB] FAIL late_ready k=%0d got %b", k, r0); end
      end
      if (k == 17) begin
        checks++; if (req0 !== 1'b1) begin fails++; $display("[TB] FAIL late_next_req got %b exp 1", req0); end
        checks++; if (gid0 !== 2'd0) begin fails++; $display("[TB] FAIL late_next_gid got %0d exp 0", gid0); end
        checks++; if (addr0 !== 8'h0A) begin fails++; $display("[TB] FAIL late_next_addr got %h exp 0a", addr0); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      v0 = 4'hF; a0 = {8'h23, 8'h22, 8'h21, 8'h20};
      rst = (k == 6);
      #1;
      if (k == 0) begin
        checks++; if (r0 !== 4'b0001) begin fails++; $display("[TB] FAIL mid_first_grant got %b exp 0001", r0); end
      end
      if (k == 6) begin
        checks++; if (req0 !== 1'b1) begin fails++; $display("[TB] FAIL mid_req_before got %b exp 1", req0); end
        checks++; if (gid0 !== 2'd1) begin fails++; $display("[TB] FAIL mid_gid_before got %0d exp 1", gid0); end
        checks++; if (cnt0 !== 16'd1) begin fails++; $display("[TB] FAIL mid_cnt_before got %0d exp 1", cnt0); end
      end
      if (k == 7) begin
        checks++; if (req0 !== 1'b0) begin fails++; $display("[TB] FAIL mid_req_after got %b exp 0", req0); end
        checks++; if (addr0 !== 8'h00) begin fails++; $display("[TB] FAIL mid_addr_after got %h exp 00", addr0); end
        checks++; if (gid0 !== 2'd0) begin fails++; $display("[TB] FAIL mid_gid_after got %0d exp 0", gid0); end
        checks++; if (cnt0 !== 16'd0) begin fails++; $display("[TB] FAIL mid_cnt_after got %0d exp 0", cnt0); end
        checks++; if (r0 !== 4'b0000) begin fails++; $display("[TB] FAIL mid_ready_ack_high got %b exp 0000", r0); end
      end
      if (k == 8) begin
        checks++; if (r0 !== 4'b0001) begin fails++; $display("[TB] FAIL mid_src0_wins got %b exp 0001", r0); end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_sync_period();
    logic [3:0] exp_ready;
    int         m;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      v1 = 4'hF; a1 = {8'h43, 8'h42, 8'h41, 8'h40};
      #1;
      m = k % 9;
      exp_ready = '0;
      if (m == 0) exp_ready[(k / 9) % 4] = 1'b1;
      checks++; if (r1 !== exp_ready) begin fails++; $display("[TB] FAIL sync_ready k=%0d got %b exp %b", k, r1, exp_ready); end
      checks++; if (req1 !== (m >= 1 && m <= 4)) begin fails++; $display("[TB] FAIL sync_req k=%0d got %b", k, req1); end
      if (m >= 1 && m <= 4) begin
        checks++; if (addr1 !== 8'h40 + 8'((k / 9) % 4)) begin fails++; $display("[TB] FAIL sync_addr k=%0d got %h", k, addr1); end
      end
      checks++; if (cnt1 !== 16'((k + 4) / 9)) begin fails++; $display("[TB] FAIL sync_cnt k=%0d got %0d exp %0d", k, cnt1, (k + 4) / 9); end
    end
  endtask

  task automatic test_saturation();
    int e;
    do_reset();
    @(negedge clk);
    force dut1.EVT_CNT = 16'hFFFD;
    @(negedge clk);
    release dut1.EVT_CNT;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      v1 = 4'b0001; a1 = {24'h0, 8'h99};
      #1;
      e = 16'hFFFD + (k + 4) / 9;
      if (e > 16'hFFFF) e = 16'hFFFF;
      checks++; if (cnt1 !== 16'(e)) begin fails++; $display("[TB] FAIL sat_cnt k=%0d got %h exp %h", k, cnt1, 16'(e)); end
    end
  endtask

  initial begin
    #500000;
    fails++;
    $display("[TB] FAIL watchdog expired got running exp finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_source();
    test_fairness();
    test_random();
    test_timeout();
    test_late_ack();
    test_reset_mid();
    test_sync_period();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/aer_tx_arbiter.md
# aer_tx_arbiter

Round-robin arbiter and 4-phase handshake sequencer that shares one AER output bus (AEROUT_REQ / AEROUT_ADDR / AEROUT_ACK) between NUM_SRC on-chip spike sources. Sits between the neuron-core event emitters and the AER receiver: accepts one event per valid/ready transfer, drives the full REQ/ACK cycle, and recovers from a stuck ACK by timeout. Also keeps a saturating count of sent events for debug.

## Interface
- NUM_SRC, 4, number of requesting sources (2..16)
- ADDR_W, 8, AER address width
- TIMEOUT_CYC, 255, max cycles REQ stays high without ACK; 0 disables timeout
- SYNC_ACK, 0, 1 inserts a 2-flop synchronizer on AEROUT_ACK
- CLK  in  1  clock; one clock domain
- RST  in  1  reset, synchronous, active-high
- SRC_VALID  in  NUM_SRC  per-source event pending
- SRC_ADDR  in  NUM_SRC*ADDR_W  per-source address, source i at bits [i*ADDR_W +: ADDR_W]
- SRC_READY  out  NUM_SRC  one-hot transfer accept, combinational
- AEROUT_REQ  out  1  bus request, registered
- AEROUT_ADDR  out  ADDR_W  bus address, registered, stable while REQ high
- AEROUT_ACK  in  1  bus acknowledge from receiver
- GRANT_ID  out  $clog2(NUM_SRC)  index of source owning current transfer
- ERR_TIMEOUT  out  1  one-cycle pulse on timeout abort
- EVT_CNT  out  16  saturating count of ACKed events

## Operation
- States: IDLE, WAIT_ACK_HI (REQ=1), WAIT_ACK_LO (REQ=0, waiting ACK release).
- IDLE: if any SRC_VALID and synchronized ACK is low, rr arbiter selects winner w; SRC_READY[w]=1 that cycle; transfer = SRC_VALID[w] & SRC_READY[w]. On transfer: AEROUT_ADDR<=SRC_ADDR[w], GRANT_ID<=w, AEROUT_REQ<=1, pointer<=(w+1) mod NUM_SRC, -> WAIT_ACK_HI. SRC_READY all-zero in every other state.
- Priority: search starts at pointer, wraps upward; pointer resets to 0.
- WAIT_ACK_HI: timeout counter increments each cycle. ACK seen high -> AEROUT_REQ<=0, EVT_CNT<=EVT_CNT+1 (holds at 0xFFFF), -> WAIT_ACK_LO. Else if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 -> AEROUT_REQ<=0, ERR_TIMEOUT pulse, no count, -> WAIT_ACK_LO. ACK and timeout in same cycle: ACK wins.
- WAIT_ACK_LO: ACK seen low -> IDLE. No timeout here.
- IDLE with ACK still high (late ACK after timeout): no grant until ACK low.
- AEROUT_ADDR and GRANT_ID hold last value in IDLE.
- Reset (any state, any time): state IDLE, AEROUT_REQ=0, AEROUT_ADDR=0, GRANT_ID=0, ERR_TIMEOUT=0, EVT_CNT=0, pointer=0, timeout counter=0, synchronizer flops=0. In-flight event discarded; source is expected to re-present.

## Timing
- Grant cycle T (IDLE, transfer): AEROUT_REQ=1 from T+1.
- SYNC_ACK=0: ACK sampled directly; REQ falls one cycle after ACK rises; IDLE one cycle after ACK falls.
- SYNC_ACK=1: each ACK edge seen 2 cycles later; all ACK-dependent transitions delayed by 2.
- Against a same-clock receiver that ACKs one cycle after REQ: REQ high T+1..T+2, low T+3; ACK high T+2..T+3; IDLE at T+5; next grant at T+5, 5 cycles per event (9 with SYNC_ACK=1).
- Timeout: REQ high exactly TIMEOUT_CYC cycles, ERR_TIMEOUT pulse on cycle REQ first reads 0.

## Structure
- Package aer_pkg: state enum (IDLE, WAIT_ACK_HI, WAIT_ACK_LO), default ADDR_W, EVT_CNT width constant 16.
- Sub-module rr_arbiter: NUM_SRC request vector + pointer in, one-hot grant and index out, combinational; pointer register kept in aer_tx_arbiter.

## Test plan
- Single source: SRC_VALID=0001, addr 0xA5, 1-cycle-latency ACK model -> REQ high 2 cycles, AEROUT_ADDR=0xA5 while high, EVT_CNT=1, IDLE 5 cycles after grant.
- Fairness: all four valid continuously, addrs 0x10..0x13 -> bus order 0x10,0x11,0x12,0x13,0x10; each SRC_READY pulses once per round.
- Timeout: TIMEOUT_CYC=8, ACK tied 0 -> REQ high exactly 8 cycles, ERR_TIMEOUT one pulse, EVT_CNT unchanged, next grant proceeds.
- Late ACK: ACK rises 3 cycles after timeout abort and holds 4 cycles -> no grant until ACK low, no EVT_CNT increment.
- Reset mid-transfer: RST in WAIT_ACK_HI -> next cycle REQ=0, ADDR=0, EVT_CNT=0, pointer 0; source 0 wins next if all valid.
- SYNC_ACK=1, saturation: preload 65535 events (or force) -> EVT_CNT stays 0xFFFF; per-event period 9 cycles.
